// File: rtl/if_fetch_unit.sv
// if_fetch_unit
// Instruction-fetch front end that produces the PC/instruction pair for the
// IF/ID pipeline register. It walks sequential word addresses and issues them
// on a valid/ready instruction-memory port. Responses return in order with
// variable latency and are paired with their PC through a small address
// queue. They are then buffered in a BUF_DEPTH-entry FIFO. A redirect flushes
// the FIFO and restarts fetching at redirect_pc. Responses still in flight at
// that moment are counted so they can be dropped when they arrive.
//
// Ports:
//   clk              in   1   clock, rising edge
//   reset            in   1   synchronous, active-high
//   stall            in   1   hold the head entry (not consumed)
//   redirect         in   1   branch/jump taken: flush and refetch
//   redirect_pc      in  32   new fetch address (low two bits ignored)
//   imem_req_valid   out  1   fetch request valid
//   imem_req_ready   in   1   memory accepts the request this cycle
//   imem_req_addr    out 32   word-aligned fetch address
//   imem_resp_valid  in   1   in-order response valid
//   imem_resp_data   in  32   returned instruction
//   if_pc            out 32   PC of the head entry (0 when empty)
//   if_instruction   out 32   instruction of the head entry (NOP when empty)
//   if_valid         out  1   head entry valid
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [31:0] if_pc,
    output logic [31:0] if_instruction,
    output logic        if_valid
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(BUF_DEPTH);

    logic [31:0]   fetch_pc;

    logic [31:0]   buf_pc    [BUF_DEPTH];
    logic [31:0]   buf_instr [BUF_DEPTH];
    logic [PW-1:0] buf_rd;
    logic [PW-1:0] buf_wr;
    logic [CW-1:0] count;

    logic [31:0]   pcq [BUF_DEPTH];
    logic [PW-1:0] pcq_rd;
    logic [PW-1:0] pcq_wr;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;

    logic [CW:0]   occupancy;
    logic          accept;
    logic          resp_fire;
    logic          push;
    logic          pop;

    // Alignment bits of the redirect target are deliberately dropped.
    logic          unused_low_bits;
    assign unused_low_bits = ^redirect_pc[1:0];

    // Buffered plus in-flight fetches never exceed BUF_DEPTH, so every
    // response that is kept is guaranteed a free FIFO slot.
    assign occupancy      = {1'b0, count} + {1'b0, outstanding};
    assign imem_req_valid = !reset && !redirect && (occupancy < DEPTH_W);
    assign imem_req_addr  = fetch_pc;

    assign accept    = imem_req_valid && imem_req_ready;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign resp_fire = imem_resp_valid && (outstanding != '0);
    assign push      = resp_fire && (discard == '0) && !redirect;
    assign pop       = (count != '0) && !stall && !redirect;

    assign if_valid       = (count != '0);
    assign if_pc          = if_valid ? buf_pc[buf_rd] : 32'h0000_0000;
    assign if_instruction = if_valid ? buf_instr[buf_rd] : NOP_INSTR;

    // Control state. The address queue keeps popping through a redirect so
    // that stale responses stay paired with the right slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            buf_rd      <= '0;
            buf_wr      <= '0;
            count       <= '0;
            pcq_rd      <= '0;
            pcq_wr      <= '0;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            if (accept) begin
                pcq_wr <= pcq_wr + 1'b1;
            end
            if (resp_fire) begin
                pcq_rd <= pcq_rd + 1'b1;
            end
            outstanding <= outstanding + CW'(accept) - CW'(resp_fire);

            if (redirect) begin
                fetch_pc <= {redirect_pc[31:2], 2'b00};
                buf_rd   <= '0;
                buf_wr   <= '0;
                count    <= '0;
                // Everything still in flight after this edge is stale.
                discard  <= outstanding - CW'(resp_fire);
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (resp_fire && (discard != '0)) begin
                    discard <= discard - 1'b1;
                end
                if (push) begin
                    buf_wr <= buf_wr + 1'b1;
                end
                if (pop) begin
                    buf_rd <= buf_rd + 1'b1;
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Storage arrays need no reset; validity is tracked by the counters.
    always_ff @(posedge clk) begin
        if (!reset && accept) begin
            pcq[pcq_wr] <= fetch_pc;
        end
        if (!reset && push) begin
            buf_pc[buf_wr]    <= pcq[pcq_rd];
            buf_instr[buf_wr] <= imem_resp_data;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit
// Self-checking bench for if_fetch_unit (BUF_DEPTH=2). It contains an
// in-order, variable-latency instruction memory and a queue-based reference
// model of the fetch unit. Directed phases exercise start-up, stall, redirect
// with in-flight responses, back-pressure, mid-stream reset and address
// wrap. A randomized phase follows.
module tb_if_fetch_unit;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    typedef struct packed {
        logic [31:0] addr;
        int          due;
    } memReq_t;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;
    logic        if_valid;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Reference model: fetch address, buffered entries, PCs in flight and
    // the number of responses still to be thrown away.
    logic [31:0] mFetchPc  = RPC;
    entry_t      mFifo[$];
    logic [31:0] mPend[$];
    int          mDiscard  = 0;

    // Memory model: in-order request queue with a due cycle per request.
    memReq_t     memQ[$];
    int          memLat    = 1;
    bit          randLat   = 1'b0;

    if_fetch_unit #(
        .RESET_PC  (RPC),
        .BUF_DEPTH (DEPTH),
        .NOP_INSTR (NOP)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .if_pc           (if_pc),
        .if_instruction  (if_instruction),
        .if_valid        (if_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: a distinct word per address.
    function automatic logic [31:0] instrFor(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'h1357_9BDF;
    endfunction

    function automatic bit modelReqValid(input bit rst, input bit rd);
        return !rst && !rd && ((mFifo.size() + mPend.size()) < DEPTH);
    endfunction

    task automatic compare(input string tag, input logic [31:0] got,
                           input logic [31:0] want);
        vectors++;
        assert (got === want)
        else begin
            miscompares++;
            $error("[TB] FAIL %s at cycle %0d: got %h want %h", tag, cyc, got, want);
        end
    endtask

    task automatic checkOutput(input bit rst, input bit rd);
        bit expReqValid;
        expReqValid = modelReqValid(rst, rd);
        compare("req_valid", 32'(imem_req_valid), 32'(expReqValid));
        if (expReqValid) begin
            compare("req_addr", imem_req_addr, mFetchPc);
        end
        compare("if_valid", 32'(if_valid), 32'(mFifo.size() > 0));
        compare("if_pc", if_pc, (mFifo.size() > 0) ? mFifo[0].pc : 32'h0);
        compare("if_instruction", if_instruction,
                (mFifo.size() > 0) ? mFifo[0].instr : NOP);
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, then advance
    // the memory and the reference model across the rising edge.
    task automatic applyStimulus(input bit rst, input bit st, input bit rd,
                                 input logic [31:0] rpc, input bit rdy);
        bit          respNow;
        logic [31:0] respData;
        bit          accept;
        bit          resp;
        bit          popNow;
        logic [31:0] respPc;
        int          outBefore;
        int          lat;

        reset          = rst;
        stall          = st;
        redirect       = rd;
        redirect_pc    = rpc;
        imem_req_ready = rdy;
        respNow        = !rst && (memQ.size() > 0) && (memQ[0].due <= cyc);
        respData       = respNow ? instrFor(memQ[0].addr) : 32'hDEAD_BEEF;
        imem_resp_valid = respNow;
        imem_resp_data  = respData;

        #1;
        checkOutput(rst, rd);

        @(posedge clk);
        accept = modelReqValid(rst, rd) && rdy;
        respPc = 32'h0;
        if (rst) begin
            mFetchPc = RPC;
            mFifo.delete();
            mPend.delete();
            mDiscard = 0;
            memQ.delete();
        end else begin
            outBefore = mPend.size();
            resp      = respNow && (outBefore > 0);
            if (respNow) begin
                void'(memQ.pop_front());
            end
            if (resp) begin
                respPc = mPend.pop_front();
            end
            if (accept) begin
                lat = randLat ? int'($urandom_range(1, 4)) : memLat;
                mPend.push_back(mFetchPc);
                memQ.push_back('{addr: mFetchPc, due: cyc + lat});
            end
            if (rd) begin
                mFifo.delete();
                mFetchPc = {rpc[31:2], 2'b00};
                mDiscard = outBefore - int'(resp);
            end else begin
                popNow = (mFifo.size() > 0) && !st;
                if (accept) begin
                    mFetchPc = mFetchPc + 32'd4;
                end
                if (popNow) begin
                    void'(mFifo.pop_front());
                end
                if (resp) begin
                    if (mDiscard > 0) begin
                        mDiscard--;
                    end else begin
                        mFifo.push_back('{pc: respPc, instr: respData});
                    end
                end
            end
        end
        #1;
        cyc++;
    endtask

    initial begin
        bit          rRst;
        bit          rSt;
        bit          rRd;
        bit          rRdy;
        logic [31:0] rPc;

        reset           = 1'b1;
        stall           = 1'b0;
        redirect        = 1'b0;
        redirect_pc     = 32'h0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        @(posedge clk);
        #1;

        $display("[TB] start-up with single-cycle memory");
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 32'h0, 1);
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 32'h0, 1);

        $display("[TB] stall from reset release for 5 cycles");
        for (int i = 0; i < 2; i++) applyStimulus(1, 0, 0, 32'h0, 1);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 32'h0, 1);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 32'h0, 1);

        $display("[TB] latency 3, redirect with two requests in flight");
        memLat = 3;
        applyStimulus(1, 0, 0, 32'h0, 1);
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 32'h0, 1);
        applyStimulus(0, 0, 1, 32'h0000_0100, 1);
        for (int i = 0; i < 12; i++) applyStimulus(0, 0, 0, 32'h0, 1);

        $display("[TB] redirect under stall while a response arrives");
        memLat = 1;
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 32'h0, 1);
        applyStimulus(0, 1, 1, 32'h0000_0200, 1);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 32'h0, 1);

        $display("[TB] memory not ready for 4 cycles");
        applyStimulus(1, 0, 0, 32'h0, 1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 32'h0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 32'h0, 1);

        $display("[TB] reset in the middle of a stream");
        memLat = 2;
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 32'h0, 1);
        for (int i = 0; i < 2; i++) applyStimulus(0, 1, 0, 32'h0, 1);
        applyStimulus(1, 1, 0, 32'h0, 1);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 32'h0, 1);

        $display("[TB] unaligned redirect near the top of memory");
        memLat = 1;
        applyStimulus(0, 0, 1, 32'hFFFF_FFF6, 1);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 32'h0, 1);

        $display("[TB] randomized traffic");
        randLat = 1'b1;
        for (int i = 0; i < 600; i++) begin
            rRst = ($urandom_range(0, 99) < 1);
            rSt  = ($urandom_range(0, 99) < 30);
            rRd  = ($urandom_range(0, 99) < 6);
            rRdy = ($urandom_range(0, 99) < 70);
            rPc  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                               : 32'($urandom);
            applyStimulus(rRst, rSt, rRd, rPc, rRdy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
